alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU; registered one-entry response buffer.
// Latency: accept -> rsp_valid is 1 cycle. Backpressure: no grant while the buffer is full and rsp_ready is low.
module alu_core (
    input  logic [3:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        carry,
    output logic        zero
);
    logic [32:0] res;

    // Bit 32 carries the add carry, sub borrow, or the bit shifted out by shl.
    always_comb begin
        res = 33'd0;
        case (opcode)
            4'd1:    res = {1'b0, a} + {1'b0, b};
            4'd2:    res = {1'b0, a} - {1'b0, b};
            4'd3:    res = {1'b0, a} << b[4:0];
            4'd4:    res = {1'b0, a >> b[4:0]};
            4'd5:    res = {1'b0, $unsigned($signed(a) >>> b[4:0])};
            4'd6:    res = {1'b0, a & b};
            4'd7:    res = {1'b0, a | b};
            4'd8:    res = {1'b0, a ^ b};
            4'd9:    res = {1'b0, ~a};
            default: res = 33'd0;
        endcase
    end

    assign out   = res[31:0];
    assign carry = res[32];
    assign zero  = (res[31:0] == 32'd0);
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    logic        prio;
    logic        can_accept;
    logic        grant_vld;
    logic        grant_id;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;
    assign grant_vld  = !rst && can_accept && (req0_valid || req1_valid);
    // A lone requester wins outright; a tie goes to the pointer.
    assign grant_id   = (req0_valid && req1_valid) ? prio : req1_valid;
    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;

    assign alu_op = grant_id ? req1_opcode : req0_opcode;
    assign alu_a  = grant_id ? req1_a      : req0_a;
    assign alu_b  = grant_id ? req1_b      : req0_b;

    alu_core u_alu (
        .opcode (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .out    (alu_out),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            prio      <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            if (grant_vld) begin
                state     <= FULL;
                prio      <= !grant_id;
                rsp_id    <= grant_id;
                rsp_data  <= alu_out;
                rsp_carry <= alu_carry;
                rsp_zero  <= alu_zero;
            end else begin
                case (state)
                    FULL:    if (rsp_ready) state <= EMPTY;
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU from plain arithmetic: returns {zero, carry, data}.
    function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x;
        logic [31:0] fill;
        int sh;
        sh = int'(b % 32);
        x  = 64'd0;
        case (op)
            4'd1: x = {32'd0, a} + {32'd0, b};
            4'd2: x = ({32'd0, a} - {32'd0, b}) & 64'h1_FFFF_FFFF;
            4'd3: x = {32'd0, a} << sh;
            4'd4: x = {32'd0, a / (32'd1 << sh)};
            4'd5: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                x = {32'd0, (a >> sh) | fill};
            end
            4'd6: x = {32'd0, a & b};
            4'd7: x = {32'd0, a | b};
            4'd8: x = {32'd0, a ^ b};
            4'd9: x = {32'd0, 32'hFFFF_FFFF - a};
            default: x = 64'd0;
        endcase
        return {(x[31:0] == 32'd0), x[32], x[31:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        rsp_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd1, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'd1, 32'd3, 32'd4);
        cyc();
        cyc();
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_data} !== 36'd0) begin
            n_fail++; $display("FAIL reset_rsp: valid=%b id=%b c=%b z=%b data=%h want all 0",
                               rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_data);
        end
        do_reset();
    endtask

    task automatic test_add_carry();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd1, 32'hFFFF_FFFF, 32'd1);
        #2;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL add_accept: req0_ready=%b want 1", req0_ready);
        end
        cyc();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL add_carry: valid=%b id=%b data=%h c=%b z=%b want 1 0 00000000 1 1",
                               rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
        end
        cyc();
        #2;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_drain: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd2, 32'd5, 32'd3);
        set_req(1, 1'b1, 4'd2, 32'd3, 32'd5);
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL sim_grant0: ready=%b want 10", {req0_ready, req1_ready});
        end
        cyc();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry} !== {1'b1, 1'b0, 32'd2, 1'b0}) begin
            n_fail++; $display("FAIL sim_rsp0: valid=%b id=%b data=%h c=%b want 1 0 00000002 0",
                               rsp_valid, rsp_id, rsp_data, rsp_carry);
        end
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL sim_grant1: req1_ready=%b want 1", req1_ready);
        end
        cyc();
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sim_rsp1: valid=%b id=%b data=%h c=%b z=%b want 1 1 fffffffe 1 0",
                               rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd8, 32'h0000_00F0, 32'h0000_000F);
        #2;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_fill: req0_ready=%b want 1", req0_ready);
        end
        cyc();
        set_req(0, 1'b1, 4'd1, 32'd10, 32'd20);
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (req0_ready !== 1'b0 || {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 32'hFF, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: ready=%b valid=%b id=%b data=%h c=%b z=%b want 0 1 0 000000ff 0 0",
                                   i, req0_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero);
            end
            cyc();
        end
        rsp_ready = 1'b1;
        #2;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: req0_ready=%b want 1", req0_ready);
        end
        cyc();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd30}) begin
            n_fail++; $display("FAIL bp_result: valid=%b id=%b data=%h want 1 0 0000001e", rsp_valid, rsp_id, rsp_data);
        end
        cyc();
    endtask

    task automatic test_streaming();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'd1, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'd7, 32'h10, 32'h01);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
                set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
            end
            #2;
            if (k < 6) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL stream_grant[%0d]: ready=%b want %s", k, {req0_ready, req1_ready},
                                       (k % 2 == 0) ? "10" : "01");
                end
            end
            if (k > 0) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 1'((k - 1) % 2) || rsp_data !== (((k - 1) % 2 == 0) ? 32'd2 : 32'h11)) begin
                    n_fail++; $display("FAIL stream_rsp[%0d]: valid=%b id=%b data=%h want 1 %0d", k, rsp_valid, rsp_id,
                                       rsp_data, (k - 1) % 2);
                end
            end
            cyc();
        end
    endtask

    task automatic test_reset_full();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd1, 32'd7, 32'd8);
        cyc();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        rst = 1'b1;
        set_req(0, 1'b1, 4'd6, 32'hF0F0, 32'hFF00);
        set_req(1, 1'b1, 4'd6, 32'h0F0F, 32'hFFFF);
        #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL rstfull_ready: ready=%b want 00", {req0_ready, req1_ready});
        end
        cyc();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #2;
        n_checks++;
        if (rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rstfull_after: valid=%b ready=%b want 0 10", rsp_valid, {req0_ready, req1_ready});
        end
        cyc();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'hF000}) begin
            n_fail++; $display("FAIL rstfull_rsp: valid=%b id=%b data=%h want 1 0 0000f000", rsp_valid, rsp_id, rsp_data);
        end
        cyc();
    endtask

    task automatic test_illegal_shift();
        logic [3:0]  t_op [6];
        logic [31:0] t_a  [6];
        logic [31:0] t_b  [6];
        logic [33:0] t_ex [6];
        t_op = '{4'hF, 4'd3, 4'd5, 4'd4, 4'd9, 4'd0};
        t_a  = '{32'h1234, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hDEAD};
        t_b  = '{32'd0, 32'd1, 32'd4, 32'd4, 32'd0, 32'h1};
        t_ex = '{{2'b10, 32'd0}, {2'b11, 32'd0}, {2'b00, 32'hF800_0000},
                 {2'b00, 32'h0800_0000}, {2'b00, 32'hFFFF_FFFF}, {2'b10, 32'd0}};
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, t_op[i], t_a[i], t_b[i]);
            cyc();
            set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
            #2;
            n_checks++;
            if (rsp_valid !== 1'b1 || {rsp_zero, rsp_carry, rsp_data} !== t_ex[i]) begin
                n_fail++; $display("FAIL op_table[%0d]: valid=%b z=%b c=%b data=%h want z=%b c=%b data=%h", i, rsp_valid,
                                   rsp_zero, rsp_carry, rsp_data, t_ex[i][33], t_ex[i][32], t_ex[i][31:0]);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        bit          m_full;
        bit          m_last;
        logic [33:0] m_rsp;
        bit          m_id;
        bit          can, g_any;
        int          g;
        logic [31:0] ops [4];
        do_reset();
        m_full = 0;
        m_last = 1;  // after reset, a tie goes to requester 0
        m_rsp  = '0;
        m_id   = 0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                bit v;
                v = (r == 0) ? req0_valid : req1_valid;
                if (!v && $urandom_range(1, 0) == 1) begin
                    ops[0] = $urandom;
                    ops[1] = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
                    ops[2] = ($urandom_range(1, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
                    set_req(r, 1'b1, 4'($urandom_range(15, 0)), ops[1], ops[2]);
                end else if (!v) begin
                    set_req(r, 1'b0, 4'($urandom_range(15, 0)), $urandom, $urandom);
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            #2;
            can   = !m_full || rsp_ready;
            g_any = can && (req0_valid || req1_valid);
            g     = -1;
            if (g_any) g = (req0_valid && req1_valid) ? int'(!m_last) : (req1_valid ? 1 : 0);
            n_checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                n_fail++; $display("FAIL rand_grant[%0d]: ready=%b%b want grant %0d", c, req0_ready, req1_ready, g);
            end
            n_checks++;
            if (rsp_valid !== m_full || (m_full && ({rsp_zero, rsp_carry, rsp_data} !== m_rsp || rsp_id !== m_id))) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: valid=%b id=%b z=%b c=%b data=%h want valid=%b id=%b z=%b c=%b data=%h",
                                   c, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_data, m_full, m_id, m_rsp[33],
                                   m_rsp[32], m_rsp[31:0]);
            end
            if (g == 0) m_rsp = ref_alu(req0_opcode, req0_a, req0_b);
            if (g == 1) m_rsp = ref_alu(req1_opcode, req1_a, req1_b);
            if (g >= 0) begin
                m_full = 1; m_id = 1'(g); m_last = 1'(g);
            end else if (rsp_ready) begin
                m_full = 0;
            end
            cyc();
            if (g == 0) req0_valid = 1'b0;
            if (g == 1) req1_valid = 1'b0;
        end
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        test_reset();
        test_add_carry();
        test_simultaneous();
        test_backpressure();
        test_streaming();
        test_reset_full();
        test_illegal_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
